mini16_s2m_arbiter: RTL

Round-robin drain controller for the slave-to-master FIFOs of all PEs in the mini16 manycore array. It polls each PE's s2m FIFO through the `fifo_req_r` / `fifo_valid` / `fifo_r_data` read port, captures one entry at a time, and presents it to the master-side sink as a single valid/ready stream. Each entry carries the PE index, a write address and data. It sits between the PE array and the master's receive logic and is the only agent that issues FIFO read requests.

---
 rtl/mini16_s2m_arbiter_if.sv | 43 ++++
 rtl/mini16_s2m_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/mini16_s2m_arbiter_if.sv
// Bus bundle for the mini16 s2m drain arbiter: the per-PE FIFO read port and the
// single master-side valid/ready output stream.
interface mini16_s2m_arbiter_if #(
  parameter int N_PE      = 4,
  parameter int WIDTH_D   = 16,
  parameter int DEPTH_V_F = 16
);

  logic [N_PE-1:0]                       fifo_req_r;
  logic [N_PE-1:0]                       fifo_valid;
  logic [N_PE*(WIDTH_D+DEPTH_V_F)-1:0]   fifo_r_data;

  // Output stream: an entry moves on every rising edge where out_valid && out_ready;
  // once out_valid rises, out_data/out_addr/out_src hold until that edge.
  logic                                  out_valid;
  logic                                  out_ready;
  logic [WIDTH_D-1:0]                    out_data;
  logic [DEPTH_V_F-1:0]                  out_addr;
  logic [$clog2(N_PE)-1:0]               out_src;

  modport master (
    output fifo_req_r,
    input  fifo_valid,
    input  fifo_r_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_addr,
    output out_src
  );

  modport slave (
    input  fifo_req_r,
    output fifo_valid,
    output fifo_r_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_addr,
    input  out_src
  );

endinterface

// File: rtl/mini16_s2m_arbiter.sv
// Round-robin drain of the per-PE s2m FIFOs into one valid/ready stream.
// Optional multi-entry grants are compiled in with `define MINI16_S2M_ARB_BURST_EN.
module mini16_s2m_arbiter #(
  parameter int N_PE         = 4,
  parameter int WIDTH_D      = 16,
  parameter int DEPTH_V_F    = 16,
  parameter int FIFO_LATENCY = 2,
  parameter int BURST_LEN    = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     soft_reset,
  mini16_s2m_arbiter_if.master     bus,
  output logic [1:0]               dbg_state,
  output logic [$clog2(N_PE)-1:0]  dbg_ptr
);

  localparam int SRC_W   = $clog2(N_PE);
  localparam int ENTRY_W = WIDTH_D + DEPTH_V_F;
  localparam int WIN_W   = $clog2(FIFO_LATENCY + 1) + 1;

  localparam bit CFG_OK = (N_PE >= 2) && (N_PE <= 64) &&
                          (FIFO_LATENCY >= 1) && (BURST_LEN >= 1);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  if (!CFG_OK) begin : g_cfg_check
    $error("mini16_s2m_arbiter: parameter out of range");
  end

  logic [1:0]         state;
  logic [SRC_W-1:0]   ptr;
  logic [SRC_W-1:0]   ptr_adv;
  logic [WIN_W-1:0]   win_cnt;
  logic               win_last;
  logic [N_PE-1:0]    req_onehot;
  logic               sel_valid;
  logic [ENTRY_W-1:0] sel_entry;

  // Only the granted PE's valid and data slice are ever looked at.
  assign sel_valid = bus.fifo_valid[ptr];
  assign sel_entry = bus.fifo_r_data[int'(ptr)*ENTRY_W +: ENTRY_W];
  assign win_last  = (win_cnt == WIN_W'(FIFO_LATENCY));
  assign ptr_adv   = (ptr == SRC_W'(N_PE - 1)) ? '0 : ptr + 1'b1;

  always_comb begin
    req_onehot      = '0;
    req_onehot[ptr] = 1'b1;
  end

`ifdef MINI16_S2M_ARB_BURST_EN
  localparam int BC_W = $clog2(BURST_LEN) + 1;
  logic [BC_W-1:0] burst_cnt;
  logic            burst_keep;
  assign burst_keep = (int'(burst_cnt) + 1) < BURST_LEN;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_REQ;
      ptr            <= '0;
      win_cnt        <= '0;
      bus.fifo_req_r <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_addr   <= '0;
      bus.out_src    <= '0;
`ifdef MINI16_S2M_ARB_BURST_EN
      burst_cnt      <= '0;
`endif
    end else if (soft_reset) begin
      // Output payload registers are left alone; out_valid low makes them don't-care.
      state          <= S_REQ;
      ptr            <= '0;
      win_cnt        <= '0;
      bus.fifo_req_r <= '0;
      bus.out_valid  <= 1'b0;
`ifdef MINI16_S2M_ARB_BURST_EN
      burst_cnt      <= '0;
`endif
    end else begin
      bus.fifo_req_r <= '0;
      case (state)
        S_REQ: begin
          bus.fifo_req_r <= req_onehot;
          win_cnt        <= '0;
          state          <= S_WAIT;
        end
        S_WAIT: begin
          // A valid on the final window cycle still wins over the timeout.
          if (sel_valid) begin
            bus.out_data  <= sel_entry[WIDTH_D-1:0];
            bus.out_addr  <= sel_entry[ENTRY_W-1:WIDTH_D];
            bus.out_src   <= ptr;
            bus.out_valid <= 1'b1;
            state         <= S_HOLD;
          end else if (win_last) begin
            ptr   <= ptr_adv;
            state <= S_REQ;
`ifdef MINI16_S2M_ARB_BURST_EN
            burst_cnt <= '0;
`endif
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= S_REQ;
`ifdef MINI16_S2M_ARB_BURST_EN
            if (burst_keep) begin
              burst_cnt <= burst_cnt + 1'b1;
            end else begin
              ptr       <= ptr_adv;
              burst_cnt <= '0;
            end
`else
            ptr <= ptr_adv;
`endif
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

  assign dbg_state = state;
  assign dbg_ptr   = ptr;

endmodule
